// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: default sizing, channel
// state encoding and the prescale normalisation rule.
package multi_timer_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 32;

  // Widest prescale value the normalisation helper handles; W must not exceed it.
  localparam int MAX_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A prescale of zero divides by one rather than stalling the channel.
  function automatic logic [MAX_W-1:0] eff_prescale(input logic [MAX_W-1:0] p);
    return (p == '0) ? MAX_W'(1) : p;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, terminal counter, IDLE/RUN FSM and a sticky
// pending flag where a new expiry beats a simultaneous clear.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_in,
  input  logic         RESET,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic [W-1:0] i_prescale,
  input  logic [W-1:0] i_max_count,
  input  logic         i_periodic,
  input  logic         i_clr,
  output logic         o_pending,
  output logic         o_running,
  output logic [W-1:0] o_count
);

  state_t       r_state;
  logic [W-1:0] r_psc_top;
  logic [W-1:0] r_max;
  logic         r_periodic;
  logic [W-1:0] r_psc;
  logic [W-1:0] r_cnt;
  logic         r_pending;

  state_t       w_state_nxt;
  logic [W-1:0] w_psc_top_nxt;
  logic [W-1:0] w_max_nxt;
  logic         w_periodic_nxt;
  logic [W-1:0] w_psc_nxt;
  logic [W-1:0] w_cnt_nxt;
  logic         w_expire;
  logic         w_pending_nxt;

  always_ff @(posedge clk_in) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_psc_top  <= '0;
      r_max      <= '0;
      r_periodic <= 1'b0;
      r_psc      <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_psc_top  <= w_psc_top_nxt;
      r_max      <= w_max_nxt;
      r_periodic <= w_periodic_nxt;
      r_psc      <= w_psc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
    end
  end

  // Start overrides both stop and any tick in the same cycle; stop freezes counters.
  always_comb begin
    w_state_nxt    = r_state;
    w_psc_top_nxt  = r_psc_top;
    w_max_nxt      = r_max;
    w_periodic_nxt = r_periodic;
    w_psc_nxt      = r_psc;
    w_cnt_nxt      = r_cnt;
    w_expire       = 1'b0;

    if (i_start) begin
      w_psc_top_nxt  = W'(eff_prescale(MAX_W'(i_prescale)) - MAX_W'(1));
      w_max_nxt      = i_max_count;
      w_periodic_nxt = i_periodic;
      w_psc_nxt      = '0;
      w_cnt_nxt      = '0;
      w_state_nxt    = ST_RUN;
    end else if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_psc == r_psc_top) begin
            w_psc_nxt = '0;
            if (r_cnt == r_max) begin
              w_cnt_nxt = '0;
              w_expire  = 1'b1;
              if (!r_periodic) w_state_nxt = ST_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + W'(1);
            end
          end else begin
            w_psc_nxt = r_psc + W'(1);
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end

    w_pending_nxt = (r_pending & ~i_clr) | w_expire;
  end

  assign o_pending = r_pending;
  assign o_running = (r_state == ST_RUN);
  assign o_count   = r_cnt;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: decodes the channel address, muxes the selected
// count back out and ORs the pending flags into a single interrupt.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  parameter  int W   = W_DEF,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           RESET,
  input  logic [CW-1:0]  cfg_ch,
  input  logic           start,
  input  logic           stop,
  input  logic [W-1:0]   prescale,
  input  logic [W-1:0]   max_count,
  input  logic           periodic,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] running,
  output logic           irq,
  output logic [W-1:0]   count_rd
);

  logic [W-1:0] w_count [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic w_sel;
    assign w_sel = (cfg_ch == CW'(g));

    timer_channel #(.W(W)) u_ch (
      .clk_in      (clk_in),
      .RESET       (RESET),
      .i_start     (start & w_sel),
      .i_stop      (stop & w_sel),
      .i_prescale  (prescale),
      .i_max_count (max_count),
      .i_periodic  (periodic),
      .i_clr       (clr[g]),
      .o_pending   (pending[g]),
      .o_running   (running[g]),
      .o_count     (w_count[g])
    );
  end

  // Addresses beyond NCH-1 read back as zero.
  always_comb begin
    count_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) count_rd = w_count[i];
    end
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus random traffic,
// compared every cycle against an elapsed-time model of each channel.
module tb_multi_timer;

  localparam int NCH_T = 4;
  localparam int W_T   = 32;

  logic              clk_in;
  logic              RESET;
  logic [1:0]        cfg_ch;
  logic              start;
  logic              stop;
  logic [W_T-1:0]    prescale;
  logic [W_T-1:0]    max_count;
  logic              periodic;
  logic [NCH_T-1:0]  clr;
  logic [NCH_T-1:0]  pending;
  logic [NCH_T-1:0]  running;
  logic              irq;
  logic [W_T-1:0]    count_rd;

  logic              sStart;
  logic              sStop;
  logic [0:0]        sCfg;
  logic [7:0]        sPrescale;
  logic [7:0]        sMax;
  logic              sPeriodic;
  logic [0:0]        sClr;
  logic [0:0]        sPending;
  logic [0:0]        sRunning;
  logic              sIrq;
  logic [7:0]        sCount;

  int nComp = 0;
  int nFail = 0;

  longint mE   [NCH_T];
  longint mEff [NCH_T];
  longint mMax [NCH_T];
  bit     mPer [NCH_T];
  bit     mRun [NCH_T];
  bit     mPend[NCH_T];

  multi_timer #(.NCH(NCH_T), .W(W_T)) u_dut (
    .clk_in    (clk_in),
    .RESET     (RESET),
    .cfg_ch    (cfg_ch),
    .start     (start),
    .stop      (stop),
    .prescale  (prescale),
    .max_count (max_count),
    .periodic  (periodic),
    .clr       (clr),
    .pending   (pending),
    .running   (running),
    .irq       (irq),
    .count_rd  (count_rd)
  );

  multi_timer #(.NCH(1), .W(8)) u_small (
    .clk_in    (clk_in),
    .RESET     (RESET),
    .cfg_ch    (sCfg),
    .start     (sStart),
    .stop      (sStop),
    .prescale  (sPrescale),
    .max_count (sMax),
    .periodic  (sPeriodic),
    .clr       (sClr),
    .pending   (sPending),
    .running   (sRunning),
    .irq       (sIrq),
    .count_rd  (sCount)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nComp++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Count is derived from run time alone: whole prescale periods, modulo the period count.
  function automatic longint modelCount(input int c);
    return (mE[c] / mEff[c]) % (mMax[c] + 1);
  endfunction

  task automatic modelStep();
    bit expd;
    for (int c = 0; c < NCH_T; c++) begin
      expd = 1'b0;
      if (!RESET) begin
        mE[c] = 0; mEff[c] = 1; mMax[c] = 0; mPer[c] = 0; mRun[c] = 0; mPend[c] = 0;
      end else begin
        if (start && cfg_ch == 2'(c)) begin
          mE[c]   = 0;
          mEff[c] = (prescale == 0) ? 1 : longint'(prescale);
          mMax[c] = longint'(max_count);
          mPer[c] = periodic;
          mRun[c] = 1'b1;
        end else if (stop && cfg_ch == 2'(c)) begin
          mRun[c] = 1'b0;
        end else if (mRun[c]) begin
          mE[c]++;
          if (mE[c] % ((mMax[c] + 1) * mEff[c]) == 0) begin
            expd = 1'b1;
            if (!mPer[c]) mRun[c] = 1'b0;
          end
        end
        mPend[c] = (mPend[c] && !clr[c]) || expd;
      end
    end
  endtask

  task automatic checkOutput();
    logic [NCH_T-1:0] ePend;
    logic [NCH_T-1:0] eRun;
    logic [W_T-1:0]   eCnt;
    for (int c = 0; c < NCH_T; c++) begin
      ePend[c] = mPend[c];
      eRun[c]  = mRun[c];
    end
    eCnt = W_T'(modelCount(int'(cfg_ch)));
    checkVal("pending", 64'(pending), 64'(ePend));
    checkVal("running", 64'(running), 64'(eRun));
    checkVal("irq", 64'(irq), 64'(|ePend));
    checkVal("count_rd", 64'(count_rd), 64'(eCnt));
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk_in);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input int ch, input int psc, input int mx, input bit per);
    cfg_ch    = 2'(ch);
    prescale  = W_T'(psc);
    max_count = W_T'(mx);
    periodic  = per;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; cfg_ch = '0; start = 0; stop = 0; prescale = '0; max_count = '0;
    periodic = 0; clr = '0;
    sStart = 0; sStop = 0; sCfg = '0; sPrescale = '0; sMax = '0; sPeriodic = 0; sClr = '0;
    cycle();
    cycle();
    checkVal("rst_pending", 64'(pending), 64'h0);
    checkVal("rst_running", 64'(running), 64'h0);
    checkVal("rst_irq", 64'(irq), 64'h0);
    RESET = 1'b1;

    // Periodic ch0: prescale 3, max 4 -> 15 edges per expiry
    applyStimulus(0, 3, 4, 1'b1);
    for (int i = 0; i < 14; i++) cycle();
    checkVal("p0_before", 64'(pending[0]), 64'h0);
    cycle();
    checkVal("p0_first", 64'(pending[0]), 64'h1);
    checkVal("p0_irq", 64'(irq), 64'h1);
    clr = 4'b0001;
    cycle();
    clr = '0;
    for (int i = 0; i < 13; i++) cycle();
    checkVal("p0_before2", 64'(pending[0]), 64'h0);
    cycle();
    checkVal("p0_second", 64'(pending[0]), 64'h1);

    // One-shot ch1: prescale 0 treated as 1, max 2 -> expiry at +3
    applyStimulus(1, 0, 2, 1'b0);
    cycle();
    cycle();
    checkVal("p1_before", 64'(pending[1]), 64'h0);
    cycle();
    checkVal("p1_expire", 64'(pending[1]), 64'h1);
    checkVal("p1_stopped", 64'(running[1]), 64'h0);
    clr = 4'b0010;
    cycle();
    clr = '0;
    for (int i = 0; i < 20; i++) cycle();
    checkVal("p1_no_repeat", 64'(pending[1]), 64'h0);

    // Set beats clear on ch2 expiring every cycle
    clr = 4'b0100;
    applyStimulus(2, 1, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checkVal("p2_set_wins", 64'(pending[2]), 64'h1);
    end
    clr = '0;

    // Restart of ch3 mid-count, then stop+start collision
    applyStimulus(3, 1, 100, 1'b1);
    for (int i = 0; i < 50; i++) cycle();
    checkVal("c3_mid", 64'(count_rd), 64'd50);
    applyStimulus(3, 1, 5, 1'b1);
    checkVal("c3_restart", 64'(count_rd), 64'd0);
    for (int i = 0; i < 5; i++) cycle();
    checkVal("p3_before", 64'(pending[3]), 64'h0);
    cycle();
    checkVal("p3_expire", 64'(pending[3]), 64'h1);
    cycle();
    cycle();
    stop = 1'b1;
    applyStimulus(3, 1, 5, 1'b1);
    stop = 1'b0;
    checkVal("c3_collide_run", 64'(running[3]), 64'h1);
    checkVal("c3_collide_cnt", 64'(count_rd), 64'd0);

    // Reset while every channel runs
    applyStimulus(1, 2, 7, 1'b1);
    checkVal("all_running", 64'(running), 64'hF);
    RESET = 1'b0;
    cycle();
    RESET = 1'b1;
    checkVal("mid_rst_pending", 64'(pending), 64'h0);
    checkVal("mid_rst_running", 64'(running), 64'h0);
    checkVal("mid_rst_count", 64'(count_rd), 64'h0);
    for (int i = 0; i < 50; i++) cycle();
    checkVal("post_rst_quiet", 64'(pending), 64'h0);

    // max=255 wrap, on the 32-bit instance and the 8-bit single-channel one
    sPrescale = 8'd1; sMax = 8'd255; sPeriodic = 1'b1; sStart = 1'b1;
    applyStimulus(0, 1, 255, 1'b1);
    sStart = 1'b0;
    for (int i = 0; i < 255; i++) cycle();
    checkVal("w255_count", 64'(count_rd), 64'd255);
    checkVal("w255_pend0", 64'(pending[0]), 64'h0);
    checkVal("s_count255", 64'(sCount), 64'd255);
    checkVal("s_pend0", 64'(sPending), 64'h0);
    cycle();
    checkVal("w255_wrap", 64'(count_rd), 64'd0);
    checkVal("w255_pend1", 64'(pending[0]), 64'h1);
    checkVal("s_wrap", 64'(sCount), 64'd0);
    checkVal("s_pend1", 64'(sPending), 64'h1);
    checkVal("s_irq", 64'(sIrq), 64'h1);
    checkVal("s_running", 64'(sRunning), 64'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r         = int'($urandom_range(0, 99));
      cfg_ch    = 2'($urandom_range(0, 3));
      start     = (r < 10);
      stop      = (r >= 7 && r < 16);
      prescale  = W_T'($urandom_range(0, 4));
      max_count = W_T'($urandom_range(0, 6));
      periodic  = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      RESET     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    start = 0; stop = 0; clr = '0; RESET = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
